// File: rtl/tttg_key_input_if.sv
// Key-side and core-side signals of the tic-tac-toe key input stage.
// The master drives the raw keys; the slave (tttg_key_input) drives the core-facing outputs.
interface tttg_key_input_if;
    // No backpressure here: play and pc are one-cycle strobes that mark the first cycle
    // of a hold, and button carries the selected cell for the whole hold, so the core
    // samples button whenever play or pc is high and needs no ready.
    logic [8:0] key_cell;
    logic       key_play;
    logic       key_pc;
    logic [8:0] button;
    logic       play;
    logic       pc;
    logic       sel_valid;
    logic       busy;
    logic       multi_err;
    logic [1:0] dbg_state;

    modport master (
        output key_cell, key_play, key_pc,
        input  button, play, pc, sel_valid, busy, multi_err, dbg_state
    );

    modport slave (
        input  key_cell, key_play, key_pc,
        output button, play, pc, sel_valid, busy, multi_err, dbg_state
    );
endinterface

// File: rtl/tttg_key_input.sv
// Key synchroniser, debouncer and one-cell selection latch in front of the tic-tac-toe core.
// Define TTTG_KEY_DEBOUNCE_EN to build the per-key debounce counters; otherwise db follows sync.
module tttg_key_input #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic clk,
    input  logic reset,
    tttg_key_input_if.slave kif
);
    localparam int NK = 11;
    localparam int HW = $clog2(HOLD_CYCLES);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || HOLD_CYCLES < 3) begin : g_param_check
        $error("tttg_key_input: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECTED = 2'd1,
        ST_HOLD     = 2'd2
    } state_e;

    // Key vector order: bits 8:0 cells, bit 9 play, bit 10 pc.
    logic [NK-1:0] raw;
    logic [NK-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NK-1:0] db, db_dly_q, db_dly_d, press_q, press_d;

    assign raw = {kif.key_pc, kif.key_play, kif.key_cell};

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        db_dly_d = db;
        press_d  = db & ~db_dly_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_dly_q <= '0;
            press_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_dly_q <= db_dly_d;
            press_q  <= press_d;
        end
    end

`ifdef TTTG_KEY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [CW-1:0] cnt_q [NK];
    logic [CW-1:0] cnt_d [NK];
    logic [NK-1:0] db_q, db_d;

    // The level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_comb begin
        for (int k = 0; k < NK; k++) begin
            cnt_d[k] = cnt_q[k];
            db_d[k]  = db_q[k];
            if (sync2_q[k] == db_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d[k]  = sync2_q[k];
                cnt_d[k] = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
            db_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db = db_q;
`else
    assign db = sync2_q;
`endif

    logic [8:0] cell_press;
    logic       one_press, multi_press, play_press, pc_press;

    assign cell_press  = press_q[8:0];
    assign one_press   = (cell_press != '0) && ((cell_press & (cell_press - 9'd1)) == '0);
    assign multi_press = (cell_press != '0) && !one_press;
    assign play_press  = press_q[9];
    assign pc_press    = press_q[10];

    state_e        state_q, state_d;
    logic [8:0]    sel_q, sel_d, button_q, button_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          play_q, play_d, pc_q, pc_d, merr_q, merr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (one_press) state_d = ST_SELECTED;
            ST_SELECTED: if (play_press || pc_press) state_d = ST_HOLD;
            ST_HOLD:     if (hcnt_q == '0) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // A play/pc press in SELECTED wins over any cell press in the same cycle.
    always_comb begin
        sel_d    = sel_q;
        hcnt_d   = hcnt_q;
        button_d = button_q;
        play_d   = 1'b0;
        pc_d     = 1'b0;
        merr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                button_d = '0;
                if (one_press)        sel_d  = cell_press;
                else if (multi_press) merr_d = 1'b1;
            end
            ST_SELECTED: begin
                button_d = '0;
                if (play_press || pc_press) begin
                    play_d   = play_press;
                    pc_d     = !play_press;
                    button_d = sel_q;
                    hcnt_d   = HW'(HOLD_CYCLES - 1);
                end else if (one_press) begin
                    sel_d = cell_press;
                end else if (multi_press) begin
                    merr_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hcnt_q == '0) begin
                    button_d = '0;
                    sel_d    = '0;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            default: begin
                button_d = '0;
                sel_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q    <= '0;
            hcnt_q   <= '0;
            button_q <= '0;
            play_q   <= 1'b0;
            pc_q     <= 1'b0;
            merr_q   <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            hcnt_q   <= hcnt_d;
            button_q <= button_d;
            play_q   <= play_d;
            pc_q     <= pc_d;
            merr_q   <= merr_d;
        end
    end

    assign kif.button    = button_q;
    assign kif.play      = play_q;
    assign kif.pc        = pc_q;
    assign kif.multi_err = merr_q;
    assign kif.sel_valid = (state_q == ST_SELECTED);
    assign kif.busy      = (state_q == ST_HOLD);
    assign kif.dbg_state = state_q;
endmodule

// File: tb/tb_tttg_key_input.sv
// Bench for tttg_key_input: directed key scenarios plus random key traffic, checked
// every cycle against a behavioural model of the key pipeline and selection rules.
module tb_tttg_key_input;
    localparam int DEB  = 4;
    localparam int HOLD = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tttg_key_input_if kif ();

    tttg_key_input #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kif  (kif)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_SEL = 1, M_HOLD = 2;
    logic [10:0]    m_s1 = '0, m_s2 = '0, m_db = '0, m_db_prev = '0, m_press = '0;
    logic [DEB-1:0] m_win [11];
    int             m_mode = M_IDLE;
    int             m_left = 0;
    logic [8:0]     m_sel = '0, m_button = '0;
    logic           m_play = 1'b0, m_pc = 1'b0, m_merr = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_db_prev = '0; m_press = '0;
            for (int k = 0; k < 11; k++) m_win[k] = '0;
            m_mode = M_IDLE; m_left = 0; m_sel = '0; m_button = '0;
            m_play = 1'b0; m_pc = 1'b0; m_merr = 1'b0;
        end else begin
            int cells;
            // selection rules, driven by last cycle's press events
            cells  = $countones(m_press[8:0]);
            m_play = 1'b0; m_pc = 1'b0; m_merr = 1'b0;
            if (m_mode == M_IDLE) begin
                m_button = '0;
                if (cells == 1) begin m_sel = m_press[8:0]; m_mode = M_SEL; end
                else if (cells > 1) m_merr = 1'b1;
            end else if (m_mode == M_SEL) begin
                m_button = '0;
                if (m_press[9] || m_press[10]) begin
                    m_play = m_press[9];
                    m_pc = !m_press[9];
                    m_button = m_sel;
                    m_left = HOLD;
                    m_mode = M_HOLD;
                end else if (cells == 1) m_sel = m_press[8:0];
                else if (cells > 1) m_merr = 1'b1;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_button = '0; m_sel = '0; m_mode = M_IDLE; end
            end
            // press = rising edge of the debounced level
`ifdef TTTG_KEY_DEBOUNCE_EN
            m_press   = m_db & ~m_db_prev;
            m_db_prev = m_db;
            for (int k = 0; k < 11; k++) begin
                m_win[k] = {m_win[k][DEB-2:0], m_s2[k]};
                if (m_win[k] == {DEB{~m_db[k]}}) m_db[k] = m_s2[k];
            end
`else
            m_press   = m_s2 & ~m_db_prev;
            m_db_prev = m_s2;
`endif
            m_s2 = m_s1;
            m_s1 = {kif.key_pc, kif.key_play, kif.key_cell};
        end
    end

    // ---------------- per-cycle scoreboard + pulse counters ----------------
    logic [8:0] btn_target = '0;
    int n_play = 0, n_pc = 0, n_merr = 0, n_btn = 0;

    always @(negedge clk) begin
        check("button", kif.button, m_button);
        check("play", kif.play, m_play);
        check("pc", kif.pc, m_pc);
        check("multi_err", kif.multi_err, m_merr);
        check("sel_valid", kif.sel_valid, m_mode == M_SEL);
        check("busy", kif.busy, m_mode == M_HOLD);
        n_play += int'(kif.play);
        n_pc   += int'(kif.pc);
        n_merr += int'(kif.multi_err);
        if (kif.button == btn_target && btn_target != '0) n_btn++;
    end

    // ---------------- driver tasks ----------------
    task automatic keys(input logic [8:0] c, input logic p, input logic q, input int n);
        kif.key_cell = c;
        kif.key_play = p;
        kif.key_pc   = q;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts(input logic [8:0] target);
        n_play = 0; n_pc = 0; n_merr = 0; n_btn = 0;
        btn_target = target;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        kif.key_cell = '0; kif.key_play = 1'b0; kif.key_pc = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_button", kif.button, 9'h000);
        check("reset_sel_valid", kif.sel_valid, 1'b0);
        reset = 1'b1;
        keys('0, 0, 0, 4);

        // select cell 5 (bit 4), then play
        clear_counts(9'h010);
        keys(9'h010, 0, 0, 10);
        check("sel_after_cell", kif.sel_valid, 1'b1);
        keys('0, 1, 0, 10);
        keys('0, 0, 0, 15);
        check("play_pulses", n_play, 1);
        check("button_010_cycles", n_btn, 4);
        check("sel_valid_after_hold", kif.sel_valid, 1'b0);

        // short glitch on cell 3, then a double press, then cell 9 alone on pc
        clear_counts(9'h100);
        keys(9'h004, 0, 0, 3);
        keys('0, 0, 0, 12);
        check("glitch_no_merr", n_merr, 0);
        keys(9'h101, 0, 0, 10);
        keys('0, 0, 0, 10);
        check("multi_err_pulses", n_merr, 1);
        keys(9'h100, 0, 0, 10);
        keys('0, 0, 0, 6);
        keys('0, 0, 1, 10);
        keys('0, 0, 0, 15);
        check("pc_pulses", n_pc, 1);
        check("button_100_cycles", n_btn, 4);

        // play and pc together: play wins
        clear_counts(9'h001);
        keys(9'h001, 0, 0, 10);
        keys('0, 0, 0, 6);
        keys('0, 1, 1, 10);
        keys('0, 0, 0, 15);
        check("play_wins_play", n_play, 1);
        check("play_wins_pc", n_pc, 0);
        check("button_001_cycles", n_btn, 4);

        // presses during HOLD are dropped
        clear_counts(9'h002);
        keys(9'h002, 0, 0, 10);
        keys('0, 0, 0, 6);
        keys('0, 1, 0, 2);
        keys(9'h008, 1, 1, 10);
        keys('0, 0, 0, 20);
        check("hold_drop_pc", n_pc, 0);
        check("hold_drop_play", n_play, 1);
        check("hold_drop_sel_valid", kif.sel_valid, 1'b0);
        check("hold_drop_busy", kif.busy, 1'b0);

        // reset in the second HOLD cycle
        keys(9'h020, 0, 0, 10);
        keys('0, 0, 0, 6);
        keys('0, 1, 0, 1);
        guard = 0;
        while (!kif.busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("busy_timeout", guard < 40, 1'b1);
        kif.key_play = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_button", kif.button, 9'h000);
        check("rst_play", kif.play, 1'b0);
        check("rst_pc", kif.pc, 1'b0);
        check("rst_busy", kif.busy, 1'b0);
        keys('0, 0, 0, 3);
        reset = 1'b1;
        keys('0, 0, 0, 3);
        clear_counts(9'h000);
        keys('0, 1, 0, 10);
        keys('0, 0, 0, 15);
        check("no_sel_no_play", n_play, 0);

        // random key traffic, including short glitches
        for (int i = 0; i < 60; i++) begin
            logic [8:0] c;
            int kind;
            kind = $urandom_range(0, 5);
            if (kind <= 2)      c = 9'(1) << $urandom_range(0, 8);
            else if (kind == 3) c = 9'($urandom_range(0, 511));
            else                c = '0;
            keys(c, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(1, 12));
            if ($urandom_range(0, 2) == 0) keys('0, 0, 0, $urandom_range(1, 10));
        end
        keys('0, 0, 0, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
